// File: rtl/pwm_pkg.sv
// Shared widths and FSM state encoding for the motor speed ramp path.
package pwm_pkg;

    localparam int SPEED_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        REVERSE = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running ramp divider: one tick every 2^RAMP_WIDTH clocks, restartable via clear.
module ramp_tick_gen #(
    parameter int RAMP_WIDTH = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    logic [RAMP_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else
            count <= count + RAMP_WIDTH'(1);
    end

    assign tick = &count;

endmodule

// File: rtl/speed_ramp_controller.sv
// Ramps motor speed one step per divider tick toward a commanded target,
// passing through zero before any direction change.
module speed_ramp_controller
    import pwm_pkg::*;
#(
    parameter int RAMP_WIDTH = 12
) (
    input  logic               FPGA_clk,
    input  logic               FPGA_reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [SPEED_W-1:0] cmd_speed,
    input  logic               cmd_dir,
    input  logic               estop,
    output logic [SPEED_W-1:0] speed,
    output logic               dir,
    output logic               at_target
);

    ramp_state_t        state;
    logic [SPEED_W-1:0] target_speed;
    logic               target_dir;
    logic [SPEED_W-1:0] step_speed;
    logic               accept;
    logic               flip;
    logic               tick;

    assign cmd_ready = !estop && (state != REVERSE);
    assign accept    = cmd_valid && cmd_ready;
    assign at_target = (state == IDLE);

    // Speed has reached zero in REVERSE: direction flips on this edge.
    assign flip = (state == REVERSE) && (speed == '0) && !estop;

    // Only ever applied when speed != target_speed, so it cannot wrap.
    assign step_speed = (speed < target_speed) ? speed + SPEED_W'(1)
                                               : speed - SPEED_W'(1);

    ramp_tick_gen #(
        .RAMP_WIDTH(RAMP_WIDTH)
    ) u_tick (
        .clk    (FPGA_clk),
        .reset_n(FPGA_reset_n),
        .clear  (accept || flip),
        .tick   (tick)
    );

    always_ff @(posedge FPGA_clk or negedge FPGA_reset_n) begin
        if (!FPGA_reset_n) begin
            state        <= IDLE;
            speed        <= '0;
            dir          <= 1'b0;
            target_speed <= '0;
            target_dir   <= 1'b0;
        end else if (estop) begin
            state        <= IDLE;
            speed        <= '0;
            target_speed <= '0;
        end else if (accept) begin
            target_speed <= cmd_speed;
            target_dir   <= cmd_dir;
            // A direction change always goes through REVERSE, even from zero,
            // so the flip lands one cycle after acceptance.
            if (cmd_dir != dir)
                state <= REVERSE;
            else if (speed != cmd_speed)
                state <= RAMP;
            else
                state <= IDLE;
        end else begin
            case (state)
                RAMP: begin
                    if (speed == target_speed) begin
                        state <= IDLE;
                    end else if (tick) begin
                        speed <= step_speed;
                        if (step_speed == target_speed)
                            state <= IDLE;
                    end
                end
                REVERSE: begin
                    if (speed == '0) begin
                        dir   <= ~dir;
                        state <= (target_speed == '0) ? IDLE : RAMP;
                    end else if (tick) begin
                        speed <= speed - SPEED_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_speed_ramp_controller.sv
// Directed checks of speed_ramp_controller with RAMP_WIDTH=2 (one step per 4 clocks).
module tb_speed_ramp_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_speed;
    logic       cmd_dir;
    logic       estop;
    logic [3:0] speed;
    logic       dir;
    logic       at_target;

    int checks   = 0;
    int failures = 0;

    speed_ramp_controller #(.RAMP_WIDTH(2)) dut (
        .FPGA_clk    (clk),
        .FPGA_reset_n(rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_speed   (cmd_speed),
        .cmd_dir     (cmd_dir),
        .estop       (estop),
        .speed       (speed),
        .dir         (dir),
        .at_target   (at_target)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command for a single edge; returns at cycle 0 (+1 after that edge).
    task automatic send(input logic [3:0] s, input logic d);
        cmd_speed = s;
        cmd_dir   = d;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; estop = 1'b0; cmd_valid = 1'b0; cmd_speed = 4'd0; cmd_dir = 1'b0;
        step();
        checks++; if (speed !== 4'd0) begin failures++; $display("FAIL reset_speed got=%0d exp=0", speed); end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir got=%0b exp=0", dir); end
        checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL reset_at_target got=%0b exp=1", at_target); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
        estop = 1'b1; #1;
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_estop got=%0b exp=0", cmd_ready); end
        estop = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (speed !== 4'd0 || dir !== 1'b0 || at_target !== 1'b1 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset got spd=%0d dir=%0b at=%0b rdy=%0b exp 0/0/1/1", speed, dir, at_target, cmd_ready);
        end
    endtask

    task automatic test_ramp_up();
        logic [3:0] exp;
        send(4'd3, 1'b0);
        checks++; if (at_target !== 1'b0) begin failures++; $display("FAIL up_at_target_c0 got=%0b exp=0", at_target); end
        for (int c = 1; c <= 12; c++) begin
            step();
            exp = 4'(c / 4);
            checks++; if (speed !== exp) begin failures++; $display("FAIL up_speed c=%0d got=%0d exp=%0d", c, speed, exp); end
            checks++; if (at_target !== (c >= 12)) begin failures++; $display("FAIL up_at_target c=%0d got=%0b", c, at_target); end
        end
    endtask

    task automatic test_reverse();
        logic [3:0] exp;
        send(4'd2, 1'b1);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rev_ready_c0 got=%0b exp=0", cmd_ready); end
        for (int c = 1; c <= 21; c++) begin
            step();
            exp = (c < 4) ? 4'd3 : (c < 8) ? 4'd2 : (c < 12) ? 4'd1 : (c < 17) ? 4'd0 : (c < 21) ? 4'd1 : 4'd2;
            checks++; if (speed !== exp) begin failures++; $display("FAIL rev_speed c=%0d got=%0d exp=%0d", c, speed, exp); end
            checks++; if (dir !== (c >= 13)) begin failures++; $display("FAIL rev_dir c=%0d got=%0b", c, dir); end
            checks++; if (cmd_ready !== (c >= 13)) begin failures++; $display("FAIL rev_ready c=%0d got=%0b", c, cmd_ready); end
            checks++; if (at_target !== (c == 21)) begin failures++; $display("FAIL rev_at_target c=%0d got=%0b", c, at_target); end
        end
    endtask

    task automatic test_retarget();
        logic [3:0] exp;
        send(4'd15, 1'b1);
        repeat (12) step();
        checks++; if (speed !== 4'd5) begin failures++; $display("FAIL retgt_pre_speed got=%0d exp=5", speed); end
        // Accept lands where the divider would otherwise tick next cycle.
        repeat (2) step();
        send(4'd2, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            step();
            exp = (c < 4) ? 4'd5 : (c < 8) ? 4'd4 : (c < 12) ? 4'd3 : 4'd2;
            checks++; if (speed !== exp) begin failures++; $display("FAIL retgt_speed c=%0d got=%0d exp=%0d", c, speed, exp); end
            checks++; if (at_target !== (c == 12)) begin failures++; $display("FAIL retgt_at_target c=%0d got=%0b", c, at_target); end
        end
    endtask

    task automatic test_estop();
        send(4'd9, 1'b1);
        repeat (16) step();
        checks++; if (speed !== 4'd6) begin failures++; $display("FAIL estop_pre_speed got=%0d exp=6", speed); end
        estop = 1'b1; cmd_valid = 1'b1; cmd_speed = 4'd12; cmd_dir = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL estop_ready_comb got=%0b exp=0", cmd_ready); end
        step();
        checks++; if (speed !== 4'd0) begin failures++; $display("FAIL estop_speed got=%0d exp=0", speed); end
        checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL estop_at_target got=%0b exp=1", at_target); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL estop_ready got=%0b exp=0", cmd_ready); end
        checks++; if (dir !== 1'b1) begin failures++; $display("FAIL estop_dir_hold got=%0b exp=1", dir); end
        repeat (2) step();
        estop = 1'b0; cmd_valid = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL estop_release_ready got=%0b exp=1", cmd_ready); end
        for (int c = 1; c <= 10; c++) begin
            step();
            checks++; if (speed !== 4'd0 || at_target !== 1'b1 || dir !== 1'b1) begin
                failures++; $display("FAIL estop_no_latch c=%0d got spd=%0d at=%0b dir=%0b exp 0/1/1", c, speed, at_target, dir);
            end
        end
    endtask

    task automatic test_zero_flip();
        send(4'd0, 1'b0);
        checks++; if (at_target !== 1'b0 || cmd_ready !== 1'b0 || dir !== 1'b1) begin
            failures++; $display("FAIL zflip_c0 got at=%0b rdy=%0b dir=%0b exp 0/0/1", at_target, cmd_ready, dir);
        end
        step();
        checks++; if (dir !== 1'b0 || at_target !== 1'b1 || speed !== 4'd0) begin
            failures++; $display("FAIL zflip_c1 got dir=%0b at=%0b spd=%0d exp 0/1/0", dir, at_target, speed);
        end
        send(4'd2, 1'b1);
        step();
        checks++; if (dir !== 1'b1 || at_target !== 1'b0) begin
            failures++; $display("FAIL zflip_ramp_c1 got dir=%0b at=%0b exp 1/0", dir, at_target);
        end
        repeat (3) step();
        checks++; if (speed !== 4'd0) begin failures++; $display("FAIL zflip_c4 got=%0d exp=0", speed); end
        step();
        checks++; if (speed !== 4'd1) begin failures++; $display("FAIL zflip_c5 got=%0d exp=1", speed); end
        repeat (4) step();
        checks++; if (speed !== 4'd2 || at_target !== 1'b1) begin
            failures++; $display("FAIL zflip_c9 got spd=%0d at=%0b exp 2/1", speed, at_target);
        end
    endtask

    task automatic test_reset_mid_reverse();
        send(4'd5, 1'b0);
        repeat (4) step();
        checks++; if (speed !== 4'd1 || dir !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++; $display("FAIL rstmid_pre got spd=%0d dir=%0b rdy=%0b exp 1/1/0", speed, dir, cmd_ready);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (speed !== 4'd0 || dir !== 1'b0 || at_target !== 1'b1 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL rstmid_async got spd=%0d dir=%0b at=%0b rdy=%0b exp 0/0/1/1", speed, dir, at_target, cmd_ready);
        end
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++; if (speed !== 4'd0 || dir !== 1'b0 || at_target !== 1'b1) begin
                failures++; $display("FAIL rstmid_residual c=%0d got spd=%0d dir=%0b at=%0b", c, speed, dir, at_target);
            end
        end
    endtask

    task automatic test_saturate();
        send(4'd15, 1'b0);
        repeat (59) step();
        checks++; if (speed !== 4'd14 || at_target !== 1'b0) begin
            failures++; $display("FAIL sat_c59 got spd=%0d at=%0b exp 14/0", speed, at_target);
        end
        step();
        checks++; if (speed !== 4'd15 || at_target !== 1'b1) begin
            failures++; $display("FAIL sat_c60 got spd=%0d at=%0b exp 15/1", speed, at_target);
        end
        repeat (8) step();
        checks++; if (speed !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", speed); end
        send(4'd15, 1'b0);
        checks++; if (at_target !== 1'b1 || speed !== 4'd15) begin
            failures++; $display("FAIL sat_same_cmd got spd=%0d at=%0b exp 15/1", speed, at_target);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reverse();
        test_retarget();
        test_estop();
        test_zero_flip();
        test_reset_mid_reverse();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
